// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: first-word fall-through read port, sticky overrun flag,
// synchronous flush, and occupancy/level flags decoded from the registered count only.
module uart_rx_fifo #(
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned DEPTH_SIZE        = 4,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_wr_stb,
  input  logic                  i_flush,
  input  logic                  i_clr_ovr,
  output logic [7:0]            o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DEPTH_SIZE:0]   o_count,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overrun
);

  localparam logic [DEPTH_SIZE:0] CntFull = (DEPTH_SIZE + 1)'(DEPTH);
  localparam logic [DEPTH_SIZE:0] CntAf   = (DEPTH_SIZE + 1)'(ALMOST_FULL_LEVEL);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_SIZE-1:0] r_wr_ptr;
  logic [DEPTH_SIZE-1:0] r_rd_ptr;
  logic [DEPTH_SIZE:0]   r_count;
  logic                  r_overrun;
  logic                  r_run;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_flush;
  logic w_clr;

  // Reset release is registered: the first edge after deassertion only arms r_run, so the
  // earliest accepted push lands on the second edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CntFull);
    w_flush = r_run & i_flush;
    w_clr   = r_run & i_clr_ovr;
    // Flush wins over everything in its cycle, so it also masks the handshakes.
    w_pop   = r_run & ~i_flush & ~w_empty & i_rd_ready;
    w_push  = r_run & ~i_flush & i_wr_stb & (~w_full | w_pop);
    w_drop  = r_run & ~i_flush & i_wr_stb & w_full & ~w_pop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_clr) begin
      r_overrun <= 1'b0;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data     = r_mem[r_rd_ptr];
  assign o_rd_valid    = ~w_empty;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_almost_full = (r_count >= CntAf);
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model updated per edge, a negedge monitor that
// scores every DUT pop and flag, plus directed scenarios and a randomized soak.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_stb = 1'b0;
  logic       flush = 1'b0;
  logic       clr_ovr = 1'b0;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH(16),
    .DEPTH_SIZE(4),
    .ALMOST_FULL_LEVEL(12)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_wr_data(wr_data),
    .i_wr_stb(wr_stb),
    .i_flush(flush),
    .i_clr_ovr(clr_ovr),
    .o_rd_data(rd_data),
    .o_rd_valid(rd_valid),
    .i_rd_ready(rd_ready),
    .o_count(count),
    .o_full(full),
    .o_almost_full(almost_full),
    .o_overrun(overrun)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  bit         m_ovr = 1'b0;
  bit         m_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: occupancy, overrun and the ordered list of bytes that should come out.
  initial begin : model
    bit pop, push, drop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0;
        m_ovr = 1'b0;
        m_run = 1'b0;
        exp_q.delete();
      end else if (!m_run) begin
        m_run = 1'b1;
      end else begin
        drop = 1'b0;
        if (flush) begin
          m_cnt = 0;
          exp_q.delete();
        end else begin
          pop  = rd_ready && (m_cnt > 0);
          push = wr_stb && ((m_cnt < DEPTH) || pop);
          drop = wr_stb && !push;
          if (push) exp_q.push_back(wr_data);
          m_cnt = m_cnt + int'(push) - int'(pop);
        end
        if (drop) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
      end
    end
  end

  // Monitor: outputs are stable at the falling edge; a handshake seen here pops on the next edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      check("count", 32'(count), 32'(m_cnt));
      check("rd_valid", 32'(rd_valid), 32'(m_cnt > 0));
      check("full", 32'(full), 32'(m_cnt == DEPTH));
      check("almost_full", 32'(almost_full), 32'(m_cnt >= AFL));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (rst_n && rd_valid && rd_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_data: DUT offered 0x%02h but no byte was expected at %0t",
                   rd_data, $time);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Inputs are applied 2 time units after a rising edge and held for exactly one edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f = 1'b0, input bit c = 1'b0);
    wr_stb   = w;
    wr_data  = d;
    rd_ready = r;
    flush    = f;
    clr_ovr  = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin : stim
    int wp, rp;
    logic [7:0] seq30 [3];
    seq30[0] = 8'h55;
    seq30[1] = 8'hA3;
    seq30[2] = 8'h0F;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    // First edge after release must be ignored.
    step(1'b1, 8'hEE, 1'b0);
    check("first_edge_ignored", 32'(count), 32'd0);

    // Three writes, then continuous reads.
    for (int i = 0; i < 3; i++) step(1'b1, seq30[i], 1'b0);
    check("three_count", 32'(count), 32'd3);
    check("three_head", 32'(rd_data), 32'h55);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    check("three_drained", 32'(rd_valid), 32'd0);

    // Overfill with 17 bytes.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 10) check("af_below", 32'(almost_full), 32'd0);
      if (i == 11) check("af_at_12", 32'(almost_full), 32'd1);
    end
    check("overfill_full", 32'(full), 32'd1);
    check("overfill_ovr", 32'(overrun), 32'd1);

    // Full with simultaneous write and read.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hC5, 1'b1);
    check("full_rw_count", 32'(count), 32'd16);
    check("full_rw_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Streaming through with wrap.
    step(1'b1, 8'h80, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b1);
      check("stream_count", 32'(count), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(rd_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    idle(1);
    step(1'b1, 8'h7E, 1'b0);
    check("after_rst_head", 32'(rd_data), 32'h7E);
    step(1'b0, 8'h00, 1'b1);

    // Overrun clear racing a further drop, then a clean clear, then flush.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    check("clr_vs_drop", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_alone", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    check("pre_flush_count", 32'(count), 32'd8);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);

    // Randomized soak with phases biased toward filling and draining.
    for (int k = 0; k < 3000; k++) begin
      case ((k / 300) % 3)
        0:       begin wp = 85; rp = 25; end
        1:       begin wp = 25; rp = 85; end
        default: begin wp = 50; rp = 50; end
      endcase
      step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
           $urandom_range(199) < 2, $urandom_range(99) < 4);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
